// File: rtl/accum_sequencer_pkg.sv
// Shared types and defaults for the STFT bin accumulator sequencer.
package accum_sequencer_pkg;

  // Sequencer states: idle, summing a window, presenting a sum, frame end.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int IL_DEF   = 10;
  localparam int OL_DEF   = 10;
  localparam int NACC_DEF = 10;
  localparam int NWIN_DEF = 32;
  localparam int CW_DEF   = 4;
  localparam int WW_DEF   = 5;

  // Bits needed to index n values; never less than 1 so counters keep a width.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_sequencer_acc_core.sv
// Window accumulator: OL-bit register that loads, adds (wrapping) or holds.
module accum_sequencer_acc_core #(
  parameter int IL = 10,
  parameter int OL = 10
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          i_zero,
  input  logic          i_load,
  input  logic          i_add,
  input  logic [IL-1:0] i_data,
  output logic [OL-1:0] o_acc
);

  logic [OL-1:0] acc_q;
  logic [OL-1:0] acc_d;

  // Next accumulator value: zero beats load, load beats add, else hold.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    acc_d = acc_q;
    if (i_zero)      acc_d = '0;
    else if (i_load) acc_d = OL'(i_data);
    else if (i_add)  acc_d = acc_q + OL'(i_data);
  end

  // Accumulator register, partial sum discarded on reset.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!iRSTn) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/accum_sequencer.sv
// Window sequencer for the STFT bin accumulator: groups NACC samples per
// window, presents each sum via valid/ready, and runs NWIN windows per frame.
// Optional macro ACC_ABORT_EN adds iABORT, which returns to IDLE from any state.
module accum_sequencer
  import accum_sequencer_pkg::*;
#(
  parameter int IL   = IL_DEF,
  parameter int OL   = OL_DEF,
  parameter int NACC = NACC_DEF,
  parameter int NWIN = NWIN_DEF,
  parameter int CW   = clog2(NACC),
  parameter int WW   = clog2(NWIN)
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iSTART,
  input  logic          iVALID,
  output logic          oREADY,
  input  logic [IL-1:0] iDATA,
  output logic          oCLR,
  output logic          oACC_EN,
  output logic [CW-1:0] oCNT,
  output logic [WW-1:0] oWIN,
  output logic          oVALID,
  input  logic          iREADY,
  output logic [OL-1:0] oDATA,
  output logic          oBUSY,
  output logic          oDONE
`ifdef ACC_ABORT_EN
  ,
  input  logic          iABORT
`endif
);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] win_q, win_d;
  logic          beat;
  logic          abort;
  logic          acc_zero;

`ifdef ACC_ABORT_EN
  assign abort = iABORT;
`else
  assign abort = 1'b0;
`endif

  // Ready depends on state only, so beat never loops back through iVALID.
  assign oREADY = (state_q == ST_ACC);
  assign beat   = iVALID & oREADY;

  // Next-state, counters and accumulator strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    oCLR     = 1'b0;
    oACC_EN  = 1'b0;
    acc_zero = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          state_d = ST_ACC;
          cnt_d   = '0;
          win_d   = '0;
        end
      end
      ST_ACC: begin
        if (beat) begin
          if (cnt_q == '0) oCLR    = 1'b1;
          else             oACC_EN = 1'b1;
          if (cnt_q == CW'(NACC - 1)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (iREADY) begin
          if (win_q == WW'(NWIN - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACC;
            win_d   = win_q + WW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        win_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over start and beats: drop everything and go idle.
    if (abort) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      win_d    = '0;
      oCLR     = 1'b0;
      oACC_EN  = 1'b0;
      acc_zero = 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  accum_sequencer_acc_core #(
    .IL (IL),
    .OL (OL)
  ) u_acc (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .i_zero (acc_zero),
    .i_load (oCLR),
    .i_add  (oACC_EN),
    .i_data (iDATA),
    .o_acc  (oDATA)
  );

  assign oCNT   = cnt_q;
  assign oWIN   = win_q;
  assign oVALID = (state_q == ST_HOLD);
  assign oBUSY  = (state_q != ST_IDLE);
  assign oDONE  = (state_q == ST_DONE);

endmodule
